// File: rtl/gmii_rx_pkg.sv
// Shared definitions for the GMII receive destination-IP filter.
// Contents: parser state enum, EtherType / preamble constants, IPv4 header
// offsets, the VLAN stacking limit (GMII_RX_QINQ_EN allows two tags,
// otherwise one), and a helper that picks one byte of an IPv4 address.
package gmii_rx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_DMAC,
        ST_SMAC,
        ST_ETYPE,
        ST_VLAN,
        ST_IPHDR,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_e;

    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam int          IP_DST_OFFSET = 16;
    localparam int          IP_HDR_LEN    = 20;

`ifdef GMII_RX_QINQ_EN
    localparam logic [1:0]  VLAN_MAX      = 2'd2;
`else
    localparam logic [1:0]  VLAN_MAX      = 2'd1;
`endif

    // Byte of addr expected at IPv4 header position hdr_idx (16..19, MSB first).
    function automatic logic [7:0] ip_byte(input logic [31:0] addr, input logic [4:0] hdr_idx);
        logic [7:0] b;
        case (hdr_idx)
            5'd16:   b = addr[31:24];
            5'd17:   b = addr[23:16];
            5'd18:   b = addr[15:8];
            5'd19:   b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gmii_rx_ip_filter_if.sv
// GMII receive pin bundle.
//   rxd  [7:0] receive data
//   rxdv       receive data valid
//   rxer       receive error
// master: the PHY side driving the pins; slave: the frame parser.
interface gmii_rx_ip_filter_if;
    logic [7:0] rxd;
    logic       rxdv;
    logic       rxer;

    modport master (output rxd, output rxdv, output rxer);
    modport slave  (input  rxd, input  rxdv, input  rxer);
endinterface

// File: rtl/gmii_rx_preamble_det.sv
// Preamble counter and SFD qualifier.
//   rx_clk, reset : receive clock, async active-high reset
//   in_idle/in_pre: parser is in IDLE / PRE
//   rxdv, rxd     : GMII receive valid / data
//   sfd_ok        : SFD seen in PRE after at least PRE_MIN preamble bytes
//   sfd_bad       : SFD seen in PRE with too short a preamble
module gmii_rx_preamble_det
    import gmii_rx_pkg::*;
#(
    parameter logic [7:0] SFD     = 8'h5D,
    parameter int         PRE_MIN = 7
) (
    input  logic       rx_clk,
    input  logic       reset,
    input  logic       in_idle,
    input  logic       in_pre,
    input  logic       rxdv,
    input  logic [7:0] rxd,
    output logic       sfd_ok,
    output logic       sfd_bad
);

    localparam logic [3:0] PRE_MIN_C = 4'(PRE_MIN);

    logic [3:0] pre_cnt_r;
    logic       is_pre_s;
    logic       is_sfd_s;

    assign is_pre_s = rxdv && (rxd == PREAMBLE_BYTE);
    assign is_sfd_s = in_pre && rxdv && (rxd == SFD);
    assign sfd_ok   = is_sfd_s && (pre_cnt_r >= PRE_MIN_C);
    assign sfd_bad  = is_sfd_s && (pre_cnt_r <  PRE_MIN_C);

    // Preamble byte count: starts at 1 on the first 0x55, saturates at 15.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            pre_cnt_r <= 4'd0;
        end else if (in_idle && is_pre_s) begin
            pre_cnt_r <= 4'd1;
        end else if (in_pre && is_pre_s) begin
            pre_cnt_r <= (pre_cnt_r == 4'd15) ? pre_cnt_r : pre_cnt_r + 4'd1;
        end else if (!in_pre) begin
            pre_cnt_r <= 4'd0;
        end
    end

endmodule

// File: rtl/gmii_rx_ip_filter.sv
// GMII receive parser and IPv4 destination filter.
// Parses preamble/SFD, destination and source MAC, up to VLAN_MAX 802.1Q
// tags (two when GMII_RX_QINQ_EN is defined, one otherwise), requires
// EtherType IPv4 and compares the header's destination address with ip2.
//   rx_clk, reset       : receive clock, async active-high reset
//   gmii (slave)        : rxd / rxdv / rxer from the PHY
//   dst_mac, src_mac    : captured MACs, first wire byte in [47:40]
//   vlan_cnt, vlan_id   : tags seen this frame, VID of the outer tag
//   ip_match/ip_mismatch: one-cycle verdict pulse after header byte 19
//   frame_err           : one-cycle pulse when a frame is dropped/aborted
//   busy                : parser not in IDLE
module gmii_rx_ip_filter
    import gmii_rx_pkg::*;
#(
    parameter logic [31:0] ip2     = 32'hC0A86466,
    parameter logic [7:0]  SFD     = 8'h5D,
    parameter int          PRE_MIN = 7
) (
    input  logic                 rx_clk,
    input  logic                 reset,
    gmii_rx_ip_filter_if.slave   gmii,
    output logic [47:0]          dst_mac,
    output logic [47:0]          src_mac,
    output logic [1:0]           vlan_cnt,
    output logic [11:0]          vlan_id,
    output logic                 ip_match,
    output logic                 ip_mismatch,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [4:0] DST_FIRST = 5'(IP_DST_OFFSET);
    localparam logic [4:0] HDR_LAST  = 5'(IP_HDR_LEN - 1);

    rx_state_e   state_r, state_next_s;
    logic [4:0]  byte_cnt_r;
    logic [7:0]  etype_hi_r;
    logic        ip_ok_r;
    logic [47:0] dst_mac_r, src_mac_r;
    logic [1:0]  vlan_cnt_r;
    logic [11:0] vlan_id_r;
    logic        ip_match_r, ip_mismatch_r, frame_err_r, busy_r;

    logic        in_frame_s, accept_s, sfd_ok_s, sfd_bad_s, ip_eq_s;
    logic        frame_err_s, ip_match_s, ip_mismatch_s;
    logic [15:0] etype_s;

    // States in which rxdv loss or rxer aborts the frame.
    assign in_frame_s = state_r inside {ST_PRE, ST_DMAC, ST_SMAC, ST_ETYPE, ST_VLAN, ST_IPHDR};
    assign accept_s   = in_frame_s && gmii.rxdv && !gmii.rxer;
    assign etype_s    = {etype_hi_r, gmii.rxd};
    assign ip_eq_s    = (gmii.rxd == ip_byte(ip2, byte_cnt_r));

    gmii_rx_preamble_det #(.SFD(SFD), .PRE_MIN(PRE_MIN)) u_pre (
        .rx_clk  (rx_clk),
        .reset   (reset),
        .in_idle (state_r == ST_IDLE),
        .in_pre  (state_r == ST_PRE),
        .rxdv    (gmii.rxdv),
        .rxd     (gmii.rxd),
        .sfd_ok  (sfd_ok_s),
        .sfd_bad (sfd_bad_s)
    );

    // Next-state and pulse decode; aborts take priority over parsing.
    always_comb begin
        state_next_s  = state_r;
        frame_err_s   = 1'b0;
        ip_match_s    = 1'b0;
        ip_mismatch_s = 1'b0;
        if (in_frame_s) begin
            if (!gmii.rxdv) begin
                state_next_s = ST_IDLE;
                frame_err_s  = 1'b1;
            end else if (gmii.rxer) begin
                state_next_s = ST_DROP;
                frame_err_s  = 1'b1;
            end else begin
                case (state_r)
                    ST_PRE: begin
                        if (sfd_ok_s) begin
                            state_next_s = ST_DMAC;
                        end else if (sfd_bad_s || (gmii.rxd != PREAMBLE_BYTE)) begin
                            state_next_s = ST_DROP;
                            frame_err_s  = 1'b1;
                        end else begin
                            state_next_s = ST_PRE;
                        end
                    end
                    ST_DMAC: begin
                        if (byte_cnt_r == 5'd5) state_next_s = ST_SMAC;
                        else                    state_next_s = ST_DMAC;
                    end
                    ST_SMAC: begin
                        if (byte_cnt_r == 5'd5) state_next_s = ST_ETYPE;
                        else                    state_next_s = ST_SMAC;
                    end
                    ST_ETYPE: begin
                        if (byte_cnt_r != 5'd1) begin
                            state_next_s = ST_ETYPE;
                        end else if (etype_s == ETH_TYPE_VLAN && vlan_cnt_r != VLAN_MAX) begin
                            state_next_s = ST_VLAN;
                        end else if (etype_s == ETH_TYPE_IPV4) begin
                            state_next_s = ST_IPHDR;
                        end else begin
                            // Unknown EtherType or one tag too many.
                            state_next_s = ST_DROP;
                            frame_err_s  = 1'b1;
                        end
                    end
                    ST_VLAN: begin
                        if (byte_cnt_r == 5'd1) state_next_s = ST_ETYPE;
                        else                    state_next_s = ST_VLAN;
                    end
                    ST_IPHDR: begin
                        if (byte_cnt_r == HDR_LAST) begin
                            state_next_s  = ST_PAYLOAD;
                            ip_match_s    = ip_ok_r && ip_eq_s;
                            ip_mismatch_s = !(ip_ok_r && ip_eq_s);
                        end else begin
                            state_next_s = ST_IPHDR;
                        end
                    end
                    default: state_next_s = state_r;
                endcase
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gmii.rxdv && gmii.rxd == PREAMBLE_BYTE) begin
                        state_next_s = ST_PRE;
                    end else if (gmii.rxdv) begin
                        state_next_s = ST_DROP;
                        frame_err_s  = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_PAYLOAD, ST_DROP: begin
                    if (!gmii.rxdv) state_next_s = ST_IDLE;
                    else            state_next_s = state_r;
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register and registered status pulses.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            frame_err_r   <= 1'b0;
            ip_match_r    <= 1'b0;
            ip_mismatch_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            busy_r        <= (state_next_s != ST_IDLE);
            frame_err_r   <= frame_err_s;
            ip_match_r    <= ip_match_s;
            ip_mismatch_r <= ip_mismatch_s;
        end
    end

    // Byte position within the current field; restarts on every state change.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            byte_cnt_r <= 5'd0;
        end else if (state_next_s != state_r || !in_frame_s) begin
            byte_cnt_r <= 5'd0;
        end else begin
            byte_cnt_r <= byte_cnt_r + 5'd1;
        end
    end

    // MAC address shift registers; they hold until the next frame overwrites them.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            dst_mac_r <= 48'h0;
            src_mac_r <= 48'h0;
        end else if (accept_s && state_r == ST_DMAC) begin
            dst_mac_r <= {dst_mac_r[39:0], gmii.rxd};
        end else if (accept_s && state_r == ST_SMAC) begin
            src_mac_r <= {src_mac_r[39:0], gmii.rxd};
        end
    end

    // EtherType high byte and running destination-address compare.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            etype_hi_r <= 8'h00;
            ip_ok_r    <= 1'b0;
        end else if (accept_s && state_r == ST_ETYPE && byte_cnt_r == 5'd0) begin
            etype_hi_r <= gmii.rxd;
        end else if (accept_s && state_r == ST_IPHDR && byte_cnt_r == DST_FIRST) begin
            ip_ok_r    <= ip_eq_s;
        end else if (accept_s && state_r == ST_IPHDR && byte_cnt_r > DST_FIRST) begin
            ip_ok_r    <= ip_ok_r && ip_eq_s;
        end
    end

    // VLAN tag count and outer VID; cleared when a new SFD is accepted.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            vlan_cnt_r <= 2'd0;
            vlan_id_r  <= 12'h000;
        end else if (accept_s && sfd_ok_s) begin
            vlan_cnt_r <= 2'd0;
            vlan_id_r  <= 12'h000;
        end else if (state_r == ST_ETYPE && state_next_s == ST_VLAN) begin
            vlan_cnt_r <= vlan_cnt_r + 2'd1;
        end else if (accept_s && state_r == ST_VLAN && vlan_cnt_r == 2'd1) begin
            // Only the outer tag (first one seen) supplies vlan_id.
            if (byte_cnt_r == 5'd0) vlan_id_r[11:8] <= gmii.rxd[3:0];
            else                    vlan_id_r[7:0]  <= gmii.rxd;
        end
    end

    assign dst_mac     = dst_mac_r;
    assign src_mac     = src_mac_r;
    assign vlan_cnt    = vlan_cnt_r;
    assign vlan_id     = vlan_id_r;
    assign ip_match    = ip_match_r;
    assign ip_mismatch = ip_mismatch_r;
    assign frame_err   = frame_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_gmii_rx_ip_filter.sv
// Directed bench for gmii_rx_ip_filter: table of frames with hand-computed
// results, plus sequences for idle noise, rxdv abort and mid-frame reset.
// Expectations for the two-tag frame follow GMII_RX_QINQ_EN.
module tb_gmii_rx_ip_filter;

`ifdef GMII_RX_QINQ_EN
    localparam bit QINQ = 1'b1;
`else
    localparam bit QINQ = 1'b0;
`endif

    localparam logic [47:0] DM = 48'h386b1c1df565;
    localparam logic [47:0] SM = 48'h0495e600edac;
    localparam logic [47:0] AD = 48'h020000000001;
    localparam logic [47:0] AS = 48'h020000000002;

    typedef struct {
        int          pre;
        int          ntag;
        logic [15:0] tci0;
        logic [15:0] tci1;
        logic [15:0] etype;
        logic [31:0] ip;
        int          err_hdr;
        logic [47:0] dmac;
        logic [47:0] smac;
        int          exp_match;
        int          exp_mism;
        int          exp_err;
        logic [1:0]  exp_vcnt;
        logic [11:0] exp_vid;
        logic [47:0] exp_dmac;
        logic [47:0] exp_smac;
    } vec_t;

    logic        rx_clk = 1'b0;
    logic        reset;
    logic [47:0] dst_mac, src_mac;
    logic [1:0]  vlan_cnt;
    logic [11:0] vlan_id;
    logic        ip_match, ip_mismatch, frame_err, busy;

    int n_pass = 0;
    int n_total = 0;
    int n_match = 0, n_mism = 0, n_err = 0, n_busy = 0;

    gmii_rx_ip_filter_if gmii ();

    gmii_rx_ip_filter dut (
        .rx_clk      (rx_clk),
        .reset       (reset),
        .gmii        (gmii),
        .dst_mac     (dst_mac),
        .src_mac     (src_mac),
        .vlan_cnt    (vlan_cnt),
        .vlan_id     (vlan_id),
        .ip_match    (ip_match),
        .ip_mismatch (ip_mismatch),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #4 rx_clk = ~rx_clk;

    // Pulse and busy counters, sampled mid-cycle.
    always @(negedge rx_clk) begin
        if (ip_match)    n_match = n_match + 1;
        if (ip_mismatch) n_mism  = n_mism + 1;
        if (frame_err)   n_err   = n_err + 1;
        if (busy)        n_busy  = n_busy + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge rx_clk);
        gmii.rxdv = dv;
        gmii.rxd  = d;
        gmii.rxer = er;
    endtask

    function automatic vec_t mk(int pre, int ntag, logic [15:0] tci0, logic [15:0] tci1,
                                logic [15:0] etype, logic [31:0] ip, int err_hdr,
                                logic [47:0] dmac, logic [47:0] smac,
                                int em, int emm, int ee, logic [1:0] evc, logic [11:0] evid,
                                logic [47:0] edm, logic [47:0] esm);
        vec_t v;
        v.pre = pre; v.ntag = ntag; v.tci0 = tci0; v.tci1 = tci1; v.etype = etype;
        v.ip = ip; v.err_hdr = err_hdr; v.dmac = dmac; v.smac = smac;
        v.exp_match = em; v.exp_mism = emm; v.exp_err = ee; v.exp_vcnt = evc;
        v.exp_vid = evid; v.exp_dmac = edm; v.exp_smac = esm;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] q[$];
        int err_idx;
        int bm, bmm, be;
        logic [7:0] hb;
        q = {};
        for (int i = 0; i < v.pre; i++) q.push_back(8'h55);
        q.push_back(8'h5D);
        for (int i = 5; i >= 0; i--) q.push_back(v.dmac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(v.smac[i*8 +: 8]);
        if (v.ntag >= 1) begin
            q.push_back(8'h81); q.push_back(8'h00);
            q.push_back(v.tci0[15:8]); q.push_back(v.tci0[7:0]);
        end
        if (v.ntag >= 2) begin
            q.push_back(8'h81); q.push_back(8'h00);
            q.push_back(v.tci1[15:8]); q.push_back(v.tci1[7:0]);
        end
        q.push_back(v.etype[15:8]); q.push_back(v.etype[7:0]);
        for (int i = 0; i < 20; i++) begin
            hb = 8'h45 ^ 8'(i);
            if (i >= 16) hb = v.ip[(19 - i)*8 +: 8];
            q.push_back(hb);
        end
        for (int i = 0; i < 4; i++) q.push_back(8'hA0 + 8'(i));
        err_idx = (v.err_hdr < 0) ? -1 : v.pre + 1 + 12 + 4*v.ntag + 2 + v.err_hdr;

        bm = n_match; bmm = n_mism; be = n_err;
        for (int i = 0; i < q.size(); i++) drive(1'b1, q[i], (i == err_idx));
        chk({tag, "_busy_in_frame"}, 128'(busy), 128'(1'b1));
        repeat (4) drive(1'b0, 8'h55, 1'b0);
        chk({tag, "_match"},    128'(n_match - bm),  128'(v.exp_match));
        chk({tag, "_mismatch"}, 128'(n_mism - bmm),  128'(v.exp_mism));
        chk({tag, "_frame_err"},128'(n_err - be),    128'(v.exp_err));
        chk({tag, "_vlan_cnt"}, 128'(vlan_cnt),      128'(v.exp_vcnt));
        chk({tag, "_vlan_id"},  128'(vlan_id),       128'(v.exp_vid));
        chk({tag, "_dst_mac"},  128'(dst_mac),       128'(v.exp_dmac));
        chk({tag, "_src_mac"},  128'(src_mac),       128'(v.exp_smac));
        chk({tag, "_busy_idle"},128'(busy),          128'(1'b0));
    endtask

    vec_t vecs[9];

    initial begin
        int bm, be, bb;
        vecs[0] = mk(8, 2, 16'hEEEF, 16'hFFFE, 16'h0800, 32'hC0A86466, -1, DM, SM,
                     QINQ ? 1 : 0, 0, QINQ ? 0 : 1, QINQ ? 2'd2 : 2'd1, 12'hEEF, DM, SM);
        vecs[1] = mk(8, 0, 16'h0, 16'h0, 16'h0800, 32'hC0A86466, -1, DM, SM, 1, 0, 0, 2'd0, 12'h000, DM, SM);
        vecs[2] = mk(8, 1, 16'hEEEF, 16'h0, 16'h0800, 32'hC0A80166, -1, AD, AS, 0, 1, 0, 2'd1, 12'hEEF, AD, AS);
        vecs[3] = mk(8, 0, 16'h0, 16'h0, 16'h86DD, 32'hC0A86466, -1, DM, SM, 0, 0, 1, 2'd0, 12'h000, DM, SM);
        vecs[4] = mk(3, 1, 16'h0123, 16'h0, 16'h0800, 32'hC0A86466, -1, AD, AS, 0, 0, 1, 2'd0, 12'h000, DM, SM);
        vecs[5] = mk(8, 1, 16'h0ABC, 16'h0, 16'h0800, 32'hC0A86466, 5, DM, SM, 0, 0, 1, 2'd1, 12'hABC, DM, SM);
        vecs[6] = mk(7, 0, 16'h0, 16'h0, 16'h0800, 32'hC0A86467, -1, AD, AS, 0, 1, 0, 2'd0, 12'h000, AD, AS);
        vecs[7] = mk(6, 1, 16'h0555, 16'h0, 16'h0800, 32'hC0A86466, -1, DM, SM, 0, 0, 1, 2'd0, 12'h000, AD, AS);
        vecs[8] = mk(20, 1, 16'h0FFE, 16'h0, 16'h0800, 32'hC0A86466, -1, DM, SM, 1, 0, 0, 2'd1, 12'hFFE, DM, SM);

        reset = 1'b1;
        gmii.rxdv = 1'b0; gmii.rxd = 8'h00; gmii.rxer = 1'b0;
        repeat (3) @(negedge rx_clk);
        chk("reset_outputs", 128'({dst_mac, src_mac, vlan_cnt, vlan_id, ip_match, ip_mismatch, frame_err, busy}), 128'(0));
        reset = 1'b0;

        // 0x55 with rxdv low must be ignored.
        bm = n_match + n_mism; be = n_err; bb = n_busy;
        repeat (30) drive(1'b0, 8'h55, 1'b0);
        chk("idle_noise_busy",   128'(n_busy - bb),         128'(0));
        chk("idle_noise_pulses", 128'(n_match + n_mism - bm + n_err - be), 128'(0));

        for (int r = 0; r < 9; r++) run_vec(vecs[r], $sformatf("row%0d", r));

        // rxdv drops inside the destination MAC.
        bm = n_match + n_mism; be = n_err;
        repeat (8) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h5D, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        chk("abort_frame_err", 128'(n_err - be), 128'(1));
        chk("abort_no_verdict", 128'(n_match + n_mism - bm), 128'(0));
        chk("abort_busy", 128'(busy), 128'(1'b0));

        // Reset in the middle of a frame clears every output at once.
        repeat (8) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h5D, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h70 + 8'(i), 1'b0);
        @(negedge rx_clk);
        reset = 1'b1;
        #1;
        chk("midframe_reset_outputs", 128'({dst_mac, src_mac, vlan_cnt, vlan_id, ip_match, ip_mismatch, frame_err, busy}), 128'(0));
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        run_vec(vecs[1], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
